// File: rtl/param_alu_seq_if.sv
// Command/result bus for param_alu_seq.
// master: stimulus/command source and result sink side.
// slave:  the ALU sequencer itself.
interface param_alu_seq_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [4:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 sweep_start;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 err;
    logic                 sweep_busy;
    logic                 end_sig;

    modport master (
        output in_valid, op, a, b, sweep_start, out_ready,
        input  in_ready, out_valid, result, err, sweep_busy, end_sig
    );

    modport slave (
        input  in_valid, op, a, b, sweep_start, out_ready,
        output in_ready, out_valid, result, err, sweep_busy, end_sig
    );
endinterface

// File: rtl/param_alu_seq.sv
// param_alu_seq: handshaked WIDTH-bit ALU with 24 ops, a restoring divider
// and a sweep mode that runs every op on one captured operand pair.
// Build option: define ALU_SEQ_DIV_EN to include the sequential divider
// (op 0F, WIDTH-cycle latency). Without it, op 0F returns all-ones with err.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for a command or sweep_start; in_ready high
// S_EXEC | single-cycle op evaluated from registered operands
// S_DIV  | restoring divide, one quotient bit per cycle (ALU_SEQ_DIV_EN)
// S_HOLD | result presented, held until out_ready
module param_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    param_alu_seq_if.slave io_bus
);
    localparam int         SHW     = $clog2(WIDTH);
    localparam logic [4:0] OP_DIV  = 5'h0F;
    localparam logic [4:0] OP_LAST = 5'h17;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
`ifdef ALU_SEQ_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_HOLD = 2'd3
    } state_t;

    state_t               r_state;
    logic [4:0]           r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_sweep;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_err;
    logic                 r_end_sig;

    logic [2*WIDTH-1:0]   w_a2;
    logic [2*WIDTH-1:0]   w_b2;
    logic [SHW-1:0]       w_sh;
    logic [2*WIDTH-1:0]   w_res;
    logic                 w_err;
    logic [4:0]           w_op_nxt;
    state_t               w_tgt_in;
    state_t               w_tgt_nxt;

    assign w_a2     = {{WIDTH{1'b0}}, r_a};
    assign w_b2     = {{WIDTH{1'b0}}, r_b};
    assign w_sh     = r_b[SHW-1:0];
    assign w_op_nxt = r_op + 5'd1;

`ifdef ALU_SEQ_DIV_EN
    localparam logic [SHW-1:0] CNT_INIT = SHW'(WIDTH - 1);

    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_quo;
    logic [SHW-1:0]       r_cnt;
    logic [WIDTH:0]       w_shift;
    logic [WIDTH:0]       w_trial;
    logic [WIDTH-1:0]     w_rem_nxt;
    logic [WIDTH-1:0]     w_quo_nxt;

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    // The remainder stays below the divisor, so bit WIDTH of the trial is a pure borrow.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_trial   = w_shift - {1'b0, r_b};
    assign w_rem_nxt = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};

    assign w_tgt_in  = (io_bus.op == OP_DIV) ? S_DIV : S_EXEC;
    assign w_tgt_nxt = (w_op_nxt == OP_DIV) ? S_DIV : S_EXEC;
`else
    assign w_tgt_in  = S_EXEC;
    assign w_tgt_nxt = S_EXEC;
`endif

    // Single-cycle op evaluation from the registered operands.
    always_comb begin
        w_res = '0;
        w_err = 1'b0;
        case (r_op)
            5'h00: w_res[WIDTH-1:0] = ~r_a;
            5'h01: w_res[WIDTH-1:0] = r_a & r_b;
            5'h02: w_res[WIDTH-1:0] = r_a | r_b;
            5'h03: w_res[WIDTH-1:0] = r_a ^ r_b;
            5'h04: w_res[WIDTH-1:0] = r_a ~^ r_b;
            5'h05: w_res[0] = (r_a == '0);
            5'h06: w_res[0] = (r_a != '0) && (r_b != '0);
            5'h07: w_res[0] = (r_a != '0) || (r_b != '0);
            5'h08: w_res[0] = &r_a;
            5'h09: w_res[0] = |r_a;
            5'h0A: w_res[0] = ^r_a;
            5'h0B: w_res[WIDTH:0] = {1'b0, r_a} + {1'b0, r_b};
            5'h0C: w_res[WIDTH-1:0] = {WIDTH{1'b0}} - r_a;
            5'h0D: w_res[WIDTH-1:0] = r_a - r_b;
            5'h0E: w_res = w_a2 * w_b2;
            // Only reached here when the divider is not built.
            5'h0F: begin
                w_res = '1;
                w_err = 1'b1;
            end
            5'h10: w_res[0] = (r_a > r_b);
            5'h11: w_res[0] = (r_a >= r_b);
            5'h12: w_res[0] = (r_a == r_b);
            5'h13: w_res[0] = (r_a != r_b);
            5'h14: w_res = w_a2 << w_sh;
            5'h15: w_res[WIDTH-1:0] = r_a >> w_sh;
            5'h16: w_res = {r_a, r_b};
            5'h17: w_res = {r_a, r_a};
            default: w_err = 1'b1;
        endcase
    end

    // Sequencer FSM with registered handshake outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sweep     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_err       <= 1'b0;
            r_end_sig   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            r_rem       <= '0;
            r_quo       <= '0;
            r_cnt       <= '0;
`endif
        end else begin
            r_end_sig <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (io_bus.sweep_start) begin
                        r_sweep    <= 1'b1;
                        r_op       <= 5'h00;
                        r_a        <= io_bus.a;
                        r_b        <= io_bus.b;
                        r_in_ready <= 1'b0;
                        r_state    <= S_EXEC;
                    end else if (io_bus.in_valid && r_in_ready) begin
                        r_op       <= io_bus.op;
                        r_a        <= io_bus.a;
                        r_b        <= io_bus.b;
                        r_in_ready <= 1'b0;
                        r_state    <= w_tgt_in;
`ifdef ALU_SEQ_DIV_EN
                        r_rem      <= '0;
                        r_quo      <= io_bus.a;
                        r_cnt      <= CNT_INIT;
`endif
                    end
                end
                S_EXEC: begin
                    r_result    <= w_res;
                    r_err       <= w_err;
                    r_out_valid <= 1'b1;
                    r_state     <= S_HOLD;
                end
`ifdef ALU_SEQ_DIV_EN
                S_DIV: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    if (r_cnt == '0) begin
                        // Divide by zero still runs the full count so latency is fixed.
                        if (r_b == '0) begin
                            r_result <= {r_a, {WIDTH{1'b1}}};
                            r_err    <= 1'b1;
                        end else begin
                            r_result <= {w_rem_nxt, w_quo_nxt};
                            r_err    <= 1'b0;
                        end
                        r_out_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt - SHW'(1);
                    end
                end
`endif
                S_HOLD: begin
                    if (io_bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_sweep && (r_op != OP_LAST)) begin
                            r_op    <= w_op_nxt;
                            r_state <= w_tgt_nxt;
`ifdef ALU_SEQ_DIV_EN
                            r_rem   <= '0;
                            r_quo   <= r_a;
                            r_cnt   <= CNT_INIT;
`endif
                        end else begin
                            r_end_sig  <= r_sweep;
                            r_sweep    <= 1'b0;
                            r_in_ready <= 1'b1;
                            r_state    <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_sweep     <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign io_bus.in_ready   = r_in_ready;
    assign io_bus.out_valid  = r_out_valid;
    assign io_bus.result     = r_result;
    assign io_bus.err        = r_err;
    assign io_bus.sweep_busy = r_sweep;
    assign io_bus.end_sig    = r_end_sig;
endmodule

// File: tb/tb_param_alu_seq.sv
// Directed bench for param_alu_seq (WIDTH=8). Divide expectations follow
// whether ALU_SEQ_DIV_EN is defined for the build.
`timescale 1ns/1ps
module tb_param_alu_seq;
    localparam int WIDTH = 8;
`ifdef ALU_SEQ_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_err = 0;
    int   n_chk = 0;

    always #5 clk = ~clk;

    param_alu_seq_if #(.WIDTH(WIDTH)) bus ();

    param_alu_seq #(.WIDTH(WIDTH)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until out_valid, bounded so a stuck DUT still reaches the summary.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [15:0] exp_res,
                          input logic exp_err, input int exp_lat);
        int lat;
        bus.op        = op;
        bus.a         = a;
        bus.b         = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        check_val({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.op       = 5'h1E;
        bus.a        = ~a;
        bus.b        = ~b;
        wait_valid(lat);
        check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_val({tag, "_res"}, 32'(bus.result), 32'(exp_res));
        check_val({tag, "_err"}, 32'(bus.err), 32'(exp_err));
        tick();
        check_val({tag, "_done_valid"}, 32'(bus.out_valid), 32'd0);
        check_val({tag, "_done_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    logic [15:0] sw_res [24];
    logic        sw_err [24];

    initial begin
        int lat;
        int n_seen;

        bus.in_valid    = 1'b0;
        bus.op          = 5'h00;
        bus.a           = '0;
        bus.b           = '0;
        bus.sweep_start = 1'b0;
        bus.out_ready   = 1'b0;

        sw_res = '{16'h00F5, 16'h0002, 16'h000B, 16'h0009, 16'h00F6, 16'h0000,
                   16'h0001, 16'h0001, 16'h0000, 16'h0001, 16'h0000, 16'h000D,
                   16'h00F6, 16'h0007, 16'h001E, 16'h0103, 16'h0001, 16'h0001,
                   16'h0000, 16'h0001, 16'h0050, 16'h0001, 16'h0A03, 16'h0A0A};
        for (int i = 0; i < 24; i++) sw_err[i] = 1'b0;
        if (!DIV_EN) begin
            sw_res[15] = 16'hFFFF;
            sw_err[15] = 1'b1;
        end

        // Reset state
        repeat (3) tick();
        check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_result", 32'(bus.result), 32'd0);
        check_val("rst_err", 32'(bus.err), 32'd0);
        check_val("rst_busy", 32'(bus.sweep_busy), 32'd0);
        check_val("rst_end", 32'(bus.end_sig), 32'd0);
        rst = 1'b0;
        tick();

        // Single-cycle ops
        run_op("add",      5'h0B, 8'd200, 8'd100, 16'h012C, 1'b0, 1);
        run_op("add_max",  5'h0B, 8'hFF,  8'hFF,  16'h01FE, 1'b0, 1);
        run_op("sub_wrap", 5'h0D, 8'h03,  8'h05,  16'h00FE, 1'b0, 1);
        run_op("neg_zero", 5'h0C, 8'h00,  8'h00,  16'h0000, 1'b0, 1);
        run_op("shl_max",  5'h14, 8'hFF,  8'h07,  16'h7F80, 1'b0, 1);
        run_op("shr_mask", 5'h15, 8'h80,  8'h0F,  16'h0001, 1'b0, 1);
        run_op("concat",   5'h16, 8'h12,  8'h34,  16'h1234, 1'b0, 1);
        run_op("undef18",  5'h18, 8'h05,  8'h05,  16'h0000, 1'b1, 1);

        // Divide
        if (DIV_EN) begin
            run_op("div",      5'h0F, 8'd100, 8'd7,  16'h020E, 1'b0, 8);
            run_op("div_zero", 5'h0F, 8'd55,  8'd0,  16'h37FF, 1'b1, 8);
            run_op("div_big",  5'h0F, 8'h13,  8'hFF, 16'h1300, 1'b0, 8);
            run_op("div_one",  5'h0F, 8'hFF,  8'h01, 16'h00FF, 1'b0, 8);
        end else begin
            run_op("nodiv",    5'h0F, 8'd9,   8'd3,  16'hFFFF, 1'b1, 1);
            run_op("nodiv2",   5'h0F, 8'd100, 8'd7,  16'hFFFF, 1'b1, 1);
        end

        // Hold under back-pressure; new commands ignored
        bus.op        = 5'h0E;
        bus.a         = 8'hFF;
        bus.b         = 8'hFF;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        wait_valid(lat);
        check_val("hold_lat", 32'(lat), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check_val("hold_res", 32'(bus.result), 32'h0000FE01);
            check_val("hold_valid", 32'(bus.out_valid), 32'd1);
            check_val("hold_in_ready", 32'(bus.in_ready), 32'd0);
            bus.in_valid = 1'b1;
            bus.op       = 5'h0B;
            bus.a        = 8'h01;
            bus.b        = 8'h01;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check_val("hold_res_end", 32'(bus.result), 32'h0000FE01);
        check_val("hold_err_end", 32'(bus.err), 32'd0);
        tick();
        check_val("hold_idle_ready", 32'(bus.in_ready), 32'd1);
        n_seen = 0;
        repeat (4) begin
            tick();
            if (bus.out_valid) n_seen++;
        end
        check_val("hold_no_extra", 32'(n_seen), 32'd0);

        // Sweep, with a competing in_valid in the start cycle
        bus.sweep_start = 1'b1;
        bus.in_valid    = 1'b1;
        bus.op          = 5'h0B;
        bus.a           = 8'h0A;
        bus.b           = 8'h03;
        bus.out_ready   = 1'b1;
        tick();
        bus.sweep_start = 1'b0;
        bus.in_valid    = 1'b0;
        bus.a           = 8'h55;
        bus.b           = 8'h55;
        check_val("sw_busy", 32'(bus.sweep_busy), 32'd1);
        check_val("sw_in_ready", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 24; i++) begin
            wait_valid(lat);
            check_val($sformatf("sw_lat_%02h", i), 32'(lat),
                      32'((DIV_EN && i == 15) ? 8 : 1));
            check_val($sformatf("sw_res_%02h", i), 32'(bus.result), 32'(sw_res[i]));
            check_val($sformatf("sw_err_%02h", i), 32'(bus.err), 32'(sw_err[i]));
            if (i == 12) begin
                check_val("sw_busy_mid", 32'(bus.sweep_busy), 32'd1);
                check_val("sw_ready_mid", 32'(bus.in_ready), 32'd0);
            end
            tick();
        end
        check_val("sw_end", 32'(bus.end_sig), 32'd1);
        check_val("sw_busy_done", 32'(bus.sweep_busy), 32'd0);
        check_val("sw_ready_done", 32'(bus.in_ready), 32'd1);
        tick();
        check_val("sw_end_pulse", 32'(bus.end_sig), 32'd0);
        check_val("sw_no_extra", 32'(bus.out_valid), 32'd0);

        // Reset mid-operation aborts without a result
        bus.op        = DIV_EN ? 5'h0F : 5'h0E;
        bus.a         = 8'd100;
        bus.b         = 8'd7;
        bus.in_valid  = 1'b1;
        bus.out_ready = DIV_EN ? 1'b1 : 1'b0;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_val("abort_valid", 32'(bus.out_valid), 32'd0);
        check_val("abort_ready", 32'(bus.in_ready), 32'd1);
        check_val("abort_result", 32'(bus.result), 32'd0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        n_seen = 0;
        repeat (12) begin
            tick();
            if (bus.out_valid) n_seen++;
        end
        check_val("abort_no_result", 32'(n_seen), 32'd0);
        run_op("undef1F", 5'h1F, 8'hA5, 8'h5A, 16'h0000, 1'b1, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
